bram_arbiter: RTL and testbench

Owns the single port of the 64K x 16 program/data BRAM and shares it between the UART I/O engine and the processor core. The block sequences the board-level flow selected by the control switches: UART load, processor clear and run, then UART dump. It is the only block driving the BRAM address, data and write-enable, and it generates the processor clock enable and clear.

---
 rtl/bram_arbiter_if.sv | 44 ++++
 rtl/bram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bram_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - switch, requester, BRAM and processor-control signals of bram_arbiter
interface bram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]        ctrlSw;
    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_done;
    logic              io_ack;
    logic [DATA_W-1:0] io_rdata;
    logic              pro_req;
    logic              pro_we;
    logic [ADDR_W-1:0] pro_addr;
    logic [DATA_W-1:0] pro_wdata;
    logic              pro_halt;
    logic              pro_ack;
    logic [DATA_W-1:0] pro_rdata;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic              pro_en;
    logic              clr;
    logic              send;
    logic [2:0]        state;
    logic              prot_err;

    modport slave (
        input  ctrlSw, io_req, io_we, io_addr, io_wdata, io_done,
        input  pro_req, pro_we, pro_addr, pro_wdata, pro_halt, bram_dout,
        output io_ack, io_rdata, pro_ack, pro_rdata,
        output bram_we, bram_addr, bram_din, pro_en, clr, send, state, prot_err
    );

    modport master (
        output ctrlSw, io_req, io_we, io_addr, io_wdata, io_done,
        output pro_req, pro_we, pro_addr, pro_wdata, pro_halt, bram_dout,
        input  io_ack, io_rdata, pro_ack, pro_rdata,
        input  bram_we, bram_addr, bram_din, pro_en, clr, send, state, prot_err
    );
endinterface

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - single-port BRAM owner sequencing UART load, processor run and UART dump
// Optional BRAM_ARB_WPROTECT_EN: blocks processor writes below PROG_WORDS and flags prot_err.
module bram_arbiter #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                CLR_CYCLES = 4,
    parameter logic [ADDR_W-1:0] PROG_WORDS = 16'h0400
) (
    input  logic          clk_100,
    input  logic          rst,
    bram_arbiter_if.slave bus
);
`ifdef BRAM_ARB_WPROTECT_EN
    localparam logic PROTECT = 1'b1;
`else
    localparam logic PROTECT = 1'b0;
`endif
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD = 3'd1, S_CLR = 3'd2,
        S_RUN  = 3'd3, S_HALT = 3'd4, S_DUMP = 3'd5
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_ISSUE, PH_WAIT} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_pro_q, src_pro_d;
    logic [2:0]        sw_meta_q, mode_q;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;
    logic              io_ack_q, io_ack_d, pro_ack_q, pro_ack_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d, pro_rdata_q, pro_rdata_d;
    logic              pro_en_q, pro_en_d, clr_q, clr_d, send_q, send_d;
    logic              prot_err_q, prot_err_d;
    logic              mode_load, mode_run, mode_stop, bus_idle, prot_hit;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        src_pro_d   = src_pro_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        io_ack_d    = 1'b0;
        pro_ack_d   = 1'b0;
        io_rdata_d  = io_rdata_q;
        pro_rdata_d = pro_rdata_q;
        prot_err_d  = prot_err_q;
        mode_load   = (mode_q == 3'b010);
        mode_run    = (mode_q == 3'b001);
        mode_stop   = !mode_load && !mode_run;
        bus_idle    = (phase_q == PH_IDLE);
        prot_hit    = PROTECT && bus.pro_we && (bus.pro_addr < PROG_WORDS);

        case (state_q)
            S_IDLE: begin
                if (mode_load) begin
                    state_d = S_LOAD;
                end else if (mode_run) begin
                    state_d    = S_CLR;
                    cnt_d      = '0;
                    prot_err_d = 1'b0;
                end
            end
            S_LOAD: if (!mode_load && bus_idle) state_d = S_IDLE;
            S_CLR: begin
                if (cnt_q == CNT_W'(CLR_CYCLES - 1)) state_d = S_RUN;
                else cnt_d = cnt_q + 1'b1;
            end
            S_RUN: begin
                if (bus.pro_halt) state_d = S_HALT;
                else if (mode_stop && bus_idle) state_d = S_IDLE;
            end
            S_HALT: state_d = S_DUMP;
            S_DUMP: if (bus.io_done || (mode_stop && bus_idle)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // New accesses start only while ownership is stable; an in-flight one always finishes.
        if (bus_idle) begin
            if (state_d == state_q && (state_q == S_LOAD || state_q == S_DUMP) && bus.io_req) begin
                phase_d     = PH_ISSUE;
                src_pro_d   = 1'b0;
                bram_addr_d = bus.io_addr;
                bram_din_d  = bus.io_wdata;
                bram_we_d   = bus.io_we && (state_q == S_LOAD);
            end else if (state_d == state_q && state_q == S_RUN && bus.pro_req) begin
                phase_d     = PH_ISSUE;
                src_pro_d   = 1'b1;
                bram_addr_d = bus.pro_addr;
                bram_din_d  = bus.pro_wdata;
                bram_we_d   = bus.pro_we && !prot_hit;
                if (prot_hit) prot_err_d = 1'b1;
            end
        end else if (phase_q == PH_ISSUE) begin
            phase_d = PH_WAIT;
        end else begin
            phase_d = PH_IDLE;
            if (src_pro_q) begin
                pro_ack_d   = 1'b1;
                pro_rdata_d = bus.bram_dout;
            end else begin
                io_ack_d    = 1'b1;
                io_rdata_d  = bus.bram_dout;
            end
        end

        clr_d    = (state_d == S_CLR);
        pro_en_d = (state_d == S_RUN);
        send_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_IDLE;
            cnt_q       <= '0;
            src_pro_q   <= 1'b0;
            sw_meta_q   <= 3'b000;
            mode_q      <= 3'b000;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            io_ack_q    <= 1'b0;
            pro_ack_q   <= 1'b0;
            io_rdata_q  <= '0;
            pro_rdata_q <= '0;
            pro_en_q    <= 1'b0;
            clr_q       <= 1'b0;
            send_q      <= 1'b0;
            prot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            src_pro_q   <= src_pro_d;
            sw_meta_q   <= bus.ctrlSw;
            mode_q      <= sw_meta_q;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            io_ack_q    <= io_ack_d;
            pro_ack_q   <= pro_ack_d;
            io_rdata_q  <= io_rdata_d;
            pro_rdata_q <= pro_rdata_d;
            pro_en_q    <= pro_en_d;
            clr_q       <= clr_d;
            send_q      <= send_d;
            prot_err_q  <= prot_err_d;
        end
    end

    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.io_ack    = io_ack_q;
    assign bus.io_rdata  = io_rdata_q;
    assign bus.pro_ack   = pro_ack_q;
    assign bus.pro_rdata = pro_rdata_q;
    assign bus.pro_en    = pro_en_q;
    assign bus.clr       = clr_q;
    assign bus.send      = send_q;
    assign bus.state     = state_q;
    assign bus.prot_err  = prot_err_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - table-driven bench for bram_arbiter with a 64K x 16 read-first BRAM model
module tb_bram_arbiter;
`ifdef BRAM_ARB_WPROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk_100 = 1'b0;
    logic rst;
    always #5 clk_100 = ~clk_100;

    bram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    bram_arbiter #(.ADDR_W(16), .DATA_W(16), .CLR_CYCLES(4), .PROG_WORDS(16'h0400)) dut (
        .clk_100 (clk_100),
        .rst     (rst),
        .bus     (bus)
    );

    logic [15:0] mem [0:65535];
    always @(posedge clk_100) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr];
    end

    typedef struct {
        bit          is_pro;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        int          exp_we;
        logic [2:0]  exp_state;
    } vec_t;
    vec_t tbl [14];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input bit is_pro, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input int max_cyc, output bit acked,
                          output int lat, output int we_cnt, output logic [15:0] rd);
        acked = 1'b0; lat = 0; we_cnt = 0; rd = '0;
        if (is_pro) begin
            bus.pro_req = 1'b1; bus.pro_we = we; bus.pro_addr = addr; bus.pro_wdata = wd;
        end else begin
            bus.io_req = 1'b1; bus.io_we = we; bus.io_addr = addr; bus.io_wdata = wd;
        end
        for (int i = 1; i <= max_cyc && !acked; i++) begin
            @(negedge clk_100);
            if (bus.bram_we) we_cnt++;
            if (is_pro ? bus.pro_ack : bus.io_ack) begin
                acked = 1'b1;
                lat   = i;
                rd    = is_pro ? bus.pro_rdata : bus.io_rdata;
            end
        end
        bus.pro_req = 1'b0; bus.io_req = 1'b0; bus.pro_we = 1'b0; bus.io_we = 1'b0;
    endtask

    task automatic run_vec(input int i);
        bit acked; int lat; int we_cnt; logic [15:0] rd;
        access(tbl[i].is_pro, tbl[i].we, tbl[i].addr, tbl[i].wd, 8, acked, lat, we_cnt, rd);
        check($sformatf("v%0d_ack", i), 32'(acked), 32'd1);
        check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
        check($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(tbl[i].exp_we));
        if (!tbl[i].we) check($sformatf("v%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
        check($sformatf("v%0d_state", i), 32'(bus.state), 32'(tbl[i].exp_state));
    endtask

    task automatic wait_state(input logic [2:0] exp, input int max, input string name);
        int n = 0;
        while (bus.state !== exp && n < max) begin
            @(negedge clk_100);
            n++;
        end
        check(name, 32'(bus.state), 32'(exp));
    endtask

    initial begin
        bit acked; int lat; int we_cnt; logic [15:0] rd;
        int clr_n; int ovl;

        tbl[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1, 3'd1};
        tbl[1]  = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000, 1, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 16'h0010, 16'h0ABC, 16'h0000, 1, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0, 3'd1};
        tbl[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0ABC, 0, 3'd1};
        tbl[6]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0, 3'd3};
        tbl[7]  = '{1'b1, 1'b1, 16'h0010, 16'h7777, 16'h0000, PROT ? 0 : 1, 3'd3};
        tbl[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, PROT ? 16'h0ABC : 16'h7777, 0, 3'd3};
        tbl[9]  = '{1'b1, 1'b1, 16'h0400, 16'h2222, 16'h0000, 1, 3'd3};
        tbl[10] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 0, 3'd3};
        tbl[11] = '{1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 0, 3'd5};
        tbl[12] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0, 3'd5};
        tbl[13] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 16'h2222, 0, 3'd5};

        rst = 1'b1;
        bus.ctrlSw = 3'b000; bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = '0;
        bus.io_wdata = '0; bus.io_done = 1'b0; bus.pro_req = 1'b0; bus.pro_we = 1'b0;
        bus.pro_addr = '0; bus.pro_wdata = '0; bus.pro_halt = 1'b0;
        repeat (3) @(negedge clk_100);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_outputs", {20'(0), bus.bram_we, bus.io_ack, bus.pro_ack, bus.pro_en,
              bus.clr, bus.send, bus.prot_err}, 32'd0);
        check("rst_bus", {bus.bram_addr, bus.bram_din}, 32'd0);
        check("rst_rdata", {bus.io_rdata, bus.pro_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk_100);

        // Load phase
        bus.ctrlSw = 3'b010;
        wait_state(3'd1, 10, "enter_load");
        for (int i = 0; i <= 5; i++) run_vec(i);

        // Clear then run
        bus.ctrlSw = 3'b001;
        clr_n = 0; ovl = 0;
        for (int i = 0; i < 30 && !bus.pro_en; i++) begin
            @(negedge clk_100);
            if (bus.clr) clr_n++;
            if (bus.clr && bus.pro_en) ovl++;
        end
        check("clr_cycles", 32'(clr_n), 32'd4);
        check("clr_pro_en_overlap", 32'(ovl), 32'd0);
        check("run_pro_en", 32'(bus.pro_en), 32'd1);
        check("run_state", 32'(bus.state), 32'd3);
        for (int i = 6; i <= 10; i++) run_vec(i);
        check("prot_err_run", 32'(bus.prot_err), 32'(PROT));

        access(1'b0, 1'b1, 16'h0005, 16'hDEAD, 6, acked, lat, we_cnt, rd);
        check("io_in_run_no_ack", 32'(acked), 32'd0);
        check("io_in_run_no_we", 32'(we_cnt), 32'd0);

        // Halt and dump
        bus.pro_halt = 1'b1;
        @(negedge clk_100);
        bus.pro_halt = 1'b0;
        check("halt_state", 32'(bus.state), 32'd4);
        check("halt_pro_en", 32'(bus.pro_en), 32'd0);
        check("halt_send", 32'(bus.send), 32'd1);
        @(negedge clk_100);
        check("dump_state", 32'(bus.state), 32'd5);
        check("dump_send_low", 32'(bus.send), 32'd0);
        for (int i = 11; i <= 13; i++) run_vec(i);
        bus.io_done = 1'b1;
        @(negedge clk_100);
        bus.io_done = 1'b0;
        check("io_done_idle", 32'(bus.state), 32'd0);

        // Second run: halt coinciding with STOP must win
        wait_state(3'd3, 30, "rerun_state");
        check("prot_err_cleared", 32'(bus.prot_err), 32'd0);
        bus.ctrlSw = 3'b000;
        repeat (2) @(negedge clk_100);
        bus.pro_halt = 1'b1;
        @(negedge clk_100);
        bus.pro_halt = 1'b0;
        check("halt_wins_over_stop", 32'(bus.state), 32'd4);
        @(negedge clk_100);
        check("halt_stop_dump", 32'(bus.state), 32'd5);
        @(negedge clk_100);
        check("dump_stop_idle", 32'(bus.state), 32'd0);

        // Reset in the middle of an access
        bus.ctrlSw = 3'b010;
        wait_state(3'd1, 10, "reload_state");
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 16'h0020; bus.io_wdata = 16'h5555;
        @(negedge clk_100);
        check("rst_mid_we_issued", 32'(bus.bram_we), 32'd1);
        rst = 1'b1;
        bus.io_req = 1'b0; bus.io_we = 1'b0;
        @(negedge clk_100);
        check("rst_mid_we", 32'(bus.bram_we), 32'd0);
        check("rst_mid_ack", 32'(bus.io_ack), 32'd0);
        check("rst_mid_state", 32'(bus.state), 32'd0);
        check("rst_mid_bus", {bus.bram_addr, bus.io_rdata}, 32'd0);
        check("rst_mid_ctrl", {28'(0), bus.pro_en, bus.clr, bus.send, bus.prot_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk_100);
        check("rst_mid_no_late_ack", 32'(bus.io_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
